alu_issue_arb: RTL and testbench



---
 rtl/alu_issue_arb_pkg.sv | 27 ++
 rtl/alu_issue_arb_rr_arbiter.sv | 61 ++++++
 rtl/alu_issue_arb.sv | 159 +++++++++++++++
 tb/tb_alu_issue_arb.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_arb_pkg.sv
// Shared CPU definitions: instruction format, opcode set and id-width helper
// used by the ALU issue arbiter.
package alu_issue_arb_pkg;

    typedef enum logic [2:0] {
        OpNop = 3'd0,
        OpAdd = 3'd1,
        OpSub = 3'd2,
        OpAnd = 3'd3,
        OpOr  = 3'd4,
        OpXor = 3'd5
    } opcode_e;

    // All-zero encodes OpNop, which the ALU treats as an idle slot.
    typedef struct packed {
        opcode_e     opcode;
        logic [4:0]  rd;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
    } instruction_t;

    // Width of a requester id; never narrower than one bit.
    function automatic int unsigned alu_arb_id_w(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_issue_arb_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// wrapping, and advances the pointer past each grantee.
module rr_arbiter
    import alu_issue_arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [N-1:0]               req_i,
    input  logic                       en_i,
    output logic [N-1:0]               gnt_o,
    output logic [alu_arb_id_w(N)-1:0] gnt_idx_o,
    output logic                       gnt_any_o
);

    localparam int unsigned IdW = alu_arb_id_w(N);

    logic [IdW-1:0] ptr_q, ptr_d;
    logic [IdW-1:0] cand;
    logic           found;
    logic [IdW-1:0] found_idx;

    // Scan N slots starting at the pointer; the first active request wins.
    always_comb begin
        cand      = '0;
        found     = 1'b0;
        found_idx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IdW'((32'(ptr_q) + k) % N);
            if (en_i && !found && req_i[cand]) begin
                found     = 1'b1;
                found_idx = cand;
            end
        end
        gnt_o = '0;
        if (found) begin
            gnt_o[found_idx] = 1'b1;
        end
        gnt_idx_o = found_idx;
        gnt_any_o = found;
    end

    // Pointer moves one past the grantee; it holds when nothing is granted.
    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (found_idx == IdW'(N - 1)) ? '0 : found_idx + IdW'(1);
        end
    end

    // Pointer register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_issue_arb.sv
// Shares one ALU among NUM_REQ requesters: round-robin issue, id tagging
// through the ALU latency, and a credit-protected response FIFO.
// Optional build macro ALU_ARB_PERF_CNT_EN adds grant/stall counters.
module alu_issue_arb
    import alu_issue_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned RSP_DEPTH = 2,
    parameter int unsigned ALU_LAT   = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  instruction_t [NUM_REQ-1:0]        req_inst,
    output logic [NUM_REQ-1:0]                req_ready,
    output instruction_t                      alu_inst,
    input  instruction_t                      alu_inst_ret,
    input  logic [31:0]                       alu_result,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [alu_arb_id_w(NUM_REQ)-1:0]  rsp_id,
    output instruction_t                      rsp_inst,
    output logic [31:0]                       rsp_result
`ifdef ALU_ARB_PERF_CNT_EN
    ,
    output logic [NUM_REQ-1:0][31:0]          perf_grant_cnt,
    output logic [31:0]                       perf_stall_cnt
`endif
);

    localparam int unsigned IdW  = alu_arb_id_w(NUM_REQ);
    localparam int unsigned PtrW = alu_arb_id_w(RSP_DEPTH);
    localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);

    logic [NUM_REQ-1:0] gnt;
    logic [IdW-1:0]     gnt_idx;
    logic               gnt_any;
    logic               pop;
    logic               push;
    logic               can_issue;
    int unsigned        inflight;

    logic [ALU_LAT-1:0]           tag_vld_q;
    logic [ALU_LAT-1:0][IdW-1:0]  tag_id_q;

    logic [RSP_DEPTH-1:0][IdW-1:0] fifo_id_q;
    instruction_t [RSP_DEPTH-1:0]  fifo_inst_q;
    logic [RSP_DEPTH-1:0][31:0]    fifo_res_q;
    logic [PtrW-1:0]               wr_q;
    logic [PtrW-1:0]               rd_q;
    logic [CntW-1:0]               cnt_q;

    assign pop  = rsp_valid & rsp_ready;
    assign push = tag_vld_q[ALU_LAT-1];

    // Credit: buffered + in-flight responses, freeing the slot popped this cycle.
    always_comb begin
        inflight = 0;
        for (int unsigned i = 0; i < ALU_LAT; i++) begin
            inflight = inflight + 32'(tag_vld_q[i]);
        end
        can_issue = (32'(cnt_q) + inflight) < (RSP_DEPTH + 32'(pop));
    end

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .clk_i     (clk),
        .rst_ni    (rst),
        .req_i     (req_valid),
        .en_i      (can_issue & rst),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_any_o (gnt_any)
    );

    // Grant and ALU operand mux; idle op when nothing is granted.
    always_comb begin
        req_ready = gnt;
        alu_inst  = gnt_any ? req_inst[gnt_idx] : '0;
    end

    // Tag shift register follows each op through the ALU pipeline.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            tag_vld_q[0] <= gnt_any;
            tag_id_q[0]  <= gnt_idx;
            for (int unsigned i = 1; i < ALU_LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
        end
    end

    // FIFO storage; contents are only observed while the entry is counted.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id_q[wr_q]   <= tag_id_q[ALU_LAT-1];
            fifo_inst_q[wr_q] <= alu_inst_ret;
            fifo_res_q[wr_q]  <= alu_result;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                wr_q <= (wr_q == PtrW'(RSP_DEPTH - 1)) ? '0 : wr_q + PtrW'(1);
            end
            if (pop) begin
                rd_q <= (rd_q == PtrW'(RSP_DEPTH - 1)) ? '0 : rd_q + PtrW'(1);
            end
            cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
        end
    end

    // Head entry drives the response port; zeros while empty.
    always_comb begin
        rsp_valid  = (cnt_q != '0);
        rsp_id     = rsp_valid ? fifo_id_q[rd_q]   : '0;
        rsp_inst   = rsp_valid ? fifo_inst_q[rd_q] : '0;
        rsp_result = rsp_valid ? fifo_res_q[rd_q]  : '0;
    end

    // The credit check makes overflow unreachable.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
        !(push && (cnt_q == CntW'(RSP_DEPTH)) && !pop));

`ifdef ALU_ARB_PERF_CNT_EN
    logic [NUM_REQ-1:0][31:0] grant_cnt_q;
    logic [31:0]              stall_cnt_q;

    // Saturating grant and stall counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (gnt_any && (grant_cnt_q[gnt_idx] != '1)) begin
                grant_cnt_q[gnt_idx] <= grant_cnt_q[gnt_idx] + 32'd1;
            end
            if ((|req_valid) && !can_issue && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_grant_cnt = grant_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_arb.sv
// Bench for alu_issue_arb: registered ALU stand-in, outstanding-op queue
// model checked every cycle, plus literal checks on grant/response logs.
module tb_alu_issue_arb;
    import alu_issue_arb_pkg::*;

    localparam int NUM_REQ   = 4;
    localparam int RSP_DEPTH = 2;
    localparam int ALU_LAT   = 1;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_REQ-1:0]         req_valid;
    instruction_t [NUM_REQ-1:0] req_inst;
    logic [NUM_REQ-1:0]         req_ready;
    instruction_t               alu_inst;
    instruction_t               alu_inst_ret;
    logic [31:0]                alu_result;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [1:0]                 rsp_id;
    instruction_t               rsp_inst;
    logic [31:0]                rsp_result;
`ifdef ALU_ARB_PERF_CNT_EN
    logic [NUM_REQ-1:0][31:0]   perf_grant_cnt;
    logic [31:0]                perf_stall_cnt;
`endif

    alu_issue_arb #(
        .NUM_REQ   (NUM_REQ),
        .RSP_DEPTH (RSP_DEPTH),
        .ALU_LAT   (ALU_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_inst     (req_inst),
        .req_ready    (req_ready),
        .alu_inst     (alu_inst),
        .alu_inst_ret (alu_inst_ret),
        .alu_result   (alu_result),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_inst     (rsp_inst),
        .rsp_result   (rsp_result)
`ifdef ALU_ARB_PERF_CNT_EN
        ,
        .perf_grant_cnt (perf_grant_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_calc(instruction_t i);
        case (i.opcode)
            OpAdd:   return i.rs1_val + i.rs2_val;
            OpSub:   return i.rs1_val - i.rs2_val;
            OpAnd:   return i.rs1_val & i.rs2_val;
            OpOr:    return i.rs1_val | i.rs2_val;
            OpXor:   return i.rs1_val ^ i.rs2_val;
            default: return 32'd0;
        endcase
    endfunction

    function automatic instruction_t mk(opcode_e op, logic [31:0] a, logic [31:0] b,
                                        logic [4:0] rd);
        instruction_t r;
        r.opcode  = op;
        r.rd      = rd;
        r.rs1_val = a;
        r.rs2_val = b;
        return r;
    endfunction

    // One-cycle ALU stand-in sharing the reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            alu_inst_ret <= '0;
            alu_result   <= '0;
        end else begin
            alu_inst_ret <= alu_inst;
            alu_result   <= alu_calc(alu_inst);
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int           id;
        instruction_t inst;
        logic [31:0]  res;
        int           avail;
    } exp_t;

    exp_t        q[$];
    int          ptr_m = 0;
    int          cyc = 0;
    int unsigned m_gcnt[NUM_REQ];
    int unsigned m_stall = 0;

    int          gnt_log[$];
    int          gnt_cyc[$];
    int          rsp_id_log[$];
    logic [31:0] rsp_res_log[$];
    int          rsp_cyc[$];

    // Model and compare: one evaluation per cycle, mid-cycle.
    initial begin
        int              g;
        logic [NUM_REQ-1:0] er;
        instruction_t    ei;
        bit              ev;
        bit              pop_m;
        bit              can_m;
        exp_t            e;
        for (int i = 0; i < NUM_REQ; i++) m_gcnt[i] = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            ev    = (q.size() > 0) && (q[0].avail <= cyc);
            pop_m = ev && rsp_ready;
            can_m = (q.size() - (pop_m ? 1 : 0)) < RSP_DEPTH;
            g  = -1;
            er = '0;
            ei = '0;
            if (rst && can_m) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (g < 0 && req_valid[(ptr_m + k) % NUM_REQ]) g = (ptr_m + k) % NUM_REQ;
                end
            end
            if (g >= 0) begin
                er[g] = 1'b1;
                ei    = req_inst[g];
            end
            chk("req_ready", req_ready, er);
            chk("alu_inst", alu_inst, ei);
            chk("rsp_valid", rsp_valid, ev);
            if (ev) begin
                chk("rsp_id", rsp_id, q[0].id);
                chk("rsp_inst", rsp_inst, q[0].inst);
                chk("rsp_result", rsp_result, q[0].res);
            end
`ifdef ALU_ARB_PERF_CNT_EN
            for (int i = 0; i < NUM_REQ; i++) chk("perf_grant_cnt", perf_grant_cnt[i], m_gcnt[i]);
            chk("perf_stall_cnt", perf_stall_cnt, m_stall);
`endif
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) begin
                    gnt_log.push_back(i);
                    gnt_cyc.push_back(cyc);
                end
            end
            if (rsp_valid && rsp_ready) begin
                rsp_id_log.push_back(int'(rsp_id));
                rsp_res_log.push_back(rsp_result);
                rsp_cyc.push_back(cyc);
            end
            if (!rst) begin
                q.delete();
                ptr_m   = 0;
                m_stall = 0;
                for (int i = 0; i < NUM_REQ; i++) m_gcnt[i] = 0;
            end else begin
                if (pop_m) void'(q.pop_front());
                if (g >= 0) begin
                    e.id    = g;
                    e.inst  = req_inst[g];
                    e.res   = alu_calc(req_inst[g]);
                    e.avail = cyc + ALU_LAT + 1;
                    q.push_back(e);
                    ptr_m = (g + 1) % NUM_REQ;
                    if (m_gcnt[g] != 32'hFFFF_FFFF) m_gcnt[g]++;
                end
                if ((|req_valid) && !can_m && m_stall != 32'hFFFF_FFFF) m_stall++;
            end
            cyc++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        gnt_log.delete();
        gnt_cyc.delete();
        rsp_id_log.delete();
        rsp_res_log.delete();
        rsp_cyc.delete();
    endtask

    // Directed stimulus.
    initial begin
`ifdef ALU_ARB_PERF_CNT_EN
        logic [31:0] stall_before;
`endif
        rst         = 1'b0;
        rsp_ready   = 1'b1;
        req_valid   = '1;
        req_inst[0] = mk(OpAdd, 32'd5, 32'd3, 5'd1);
        req_inst[1] = mk(OpSub, 32'd5, 32'd3, 5'd2);
        req_inst[2] = mk(OpAnd, 32'd12, 32'd10, 5'd3);
        req_inst[3] = mk(OpXor, 32'd12, 32'd10, 5'd4);

        // Reset held with every requester active.
        step(3);
        chk("reset_req_ready", req_ready, 4'b0000);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_alu_inst", alu_inst, 72'd0);

        // Round-robin with full throughput.
        clear_logs();
        rst = 1'b1;
        step(5);
        req_valid = '0;
        step(4);
        chk("rr_gnt_count", gnt_log.size(), 5);
        for (int i = 0; i < 5; i++) chk("rr_gnt_order", gnt_log[i], i % NUM_REQ);
        chk("rr_rsp_count", rsp_id_log.size(), 5);
        for (int i = 0; i < 4; i++) chk("rr_rsp_id", rsp_id_log[i], i);
        chk("rr_add", rsp_res_log[0], 32'd8);
        chk("rr_sub", rsp_res_log[1], 32'd2);
        chk("rr_and", rsp_res_log[2], 32'd8);
        chk("rr_xor", rsp_res_log[3], 32'd6);
        chk("rr_latency", rsp_cyc[0] - gnt_cyc[0], 2);
        chk("rr_back_to_back", rsp_cyc[1] - rsp_cyc[0], 1);

        // Backpressure: two credits, then stall until a pop.
        clear_logs();
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
`ifdef ALU_ARB_PERF_CNT_EN
        stall_before = perf_stall_cnt;
`endif
        step(5);
        chk("bp_accepts", gnt_log.size(), 2);
        chk("bp_ready_low", req_ready, 4'b0000);
`ifdef ALU_ARB_PERF_CNT_EN
        chk("bp_stall_delta", perf_stall_cnt - stall_before, 32'd3);
`endif
        rsp_ready = 1'b1;
        step(1);
        chk("bp_refill_accept", gnt_log.size(), 3);
        chk("bp_one_pop", rsp_id_log.size(), 1);
        req_valid = '0;
        step(5);
        chk("bp_drained", rsp_id_log.size(), 3);

        // Sparse requests: pointer parks past req2.
        clear_logs();
        req_valid = 4'b0100;
        step(3);
        req_valid = 4'b1001;
        step(2);
        req_valid = '0;
        step(5);
        chk("sp_gnt_count", gnt_log.size(), 5);
        for (int i = 0; i < 3; i++) chk("sp_req2", gnt_log[i], 2);
        chk("sp_req3_first", gnt_log[3], 3);
        chk("sp_req0_next", gnt_log[4], 0);

        // Reset with one response buffered and one in the ALU.
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        step(2);
        chk("mr_buffered", rsp_valid, 1'b1);
        rst       = 1'b0;
        req_valid = '0;
        step(1);
        rst = 1'b1;
        clear_logs();
        rsp_ready = 1'b1;
        step(6);
        chk("mr_no_stale", rsp_id_log.size(), 0);
        chk("mr_rsp_valid", rsp_valid, 1'b0);

`ifdef ALU_ARB_PERF_CNT_EN
        // Ten grants to req1 since the last reset.
        req_valid = 4'b0010;
        step(10);
        req_valid = '0;
        chk("perf_req1_10", perf_grant_cnt[1], 32'd10);
        step(4);
`endif

        step(2);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
